// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
//   Shared types and constants for the MEM pipeline stage.
//   state_t              : access FSM state (IDLE / REQ)
//   TIMEOUT_CYCLES_DEF   : default watchdog depth (used only with MEM_TIMEOUT_EN)
//   ADDR_ALIGN_MASK      : low address bits that must be zero for a word access
//   is_misaligned()      : alignment test on the low address bits
package mem_stage_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   localparam int TIMEOUT_CYCLES_DEF = 16;

   localparam logic [1:0] ADDR_ALIGN_MASK = 2'b11;

   function automatic logic is_misaligned(input logic [1:0] addr_lsb);
      return (addr_lsb & ADDR_ALIGN_MASK) != 2'b00;
   endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg
//   MEM/WB pipeline register. A bubble cycle clears the write-enable and
//   leaves data/destination untouched; otherwise all three fields load.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     bubble              1 = insert bubble this edge
//     next_data/_wen/_regd  values to capture
//     data, reg_wen, regd   registered MEM/WB outputs
module mem_wb_reg #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bubble,
   input  logic [DATA_W-1:0] next_data,
   input  logic              next_reg_wen,
   input  logic [4:0]        next_regd,
   output logic [DATA_W-1:0] data,
   output logic              reg_wen,
   output logic [4:0]        regd
);

   always_ff @(posedge clk) begin
      if (rst) begin
         data    <= '0;
         reg_wen <= 1'b0;
         regd    <= '0;
      end else if (bubble) begin
         reg_wen <= 1'b0;
      end else begin
         data    <= next_data;
         reg_wen <= next_reg_wen;
         regd    <= next_regd;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
//   MEM pipeline stage: issues data-memory loads/stores over a req/ack bus,
//   stalls upstream while an access is outstanding and registers MEM/WB.
//   Optional feature macro: MEM_TIMEOUT_EN (REQ watchdog, sticky timeout_err).
//   Ports:
//     clk, rst                       clock, synchronous active-high reset
//     alu_res_in, st_data_in         EX/MEM ALU result (= address) and store data
//     reg_wen_in, dmem_alu_in,
//     mem_wen_in, regd_in            EX/MEM control: reg write, load, store, dest reg
//     dmem_req/we/addr/wdata         bus request (held until ack), latched
//     dmem_ack, dmem_rdata           bus completion, read data valid with ack
//     stall                          upstream holds EX/MEM while high
//     misalign_err                   1-cycle pulse for a dropped misaligned access
//     timeout_err                    sticky watchdog abort flag (0 when not built)
//     wb_data, wb_reg_wen, wb_regd   MEM/WB register outputs
//
//   state | meaning
//   IDLE  | no access outstanding; a new aligned access issues from here
//   REQ   | dmem_req held with latched addr/wdata/we until ack (or watchdog)
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DATA_W = 32
`ifdef MEM_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] alu_res_in,
   input  logic [DATA_W-1:0] st_data_in,
   input  logic              reg_wen_in,
   input  logic              dmem_alu_in,
   input  logic              mem_wen_in,
   input  logic [4:0]        regd_in,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              stall,
   output logic              misalign_err,
   output logic              timeout_err,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_reg_wen,
   output logic [4:0]        wb_regd
);

   state_t state;

   logic access;
   logic misalign_drop;
   logic issue;
   logic ack_hit;
   logic tmo_hit;

   // A load+store flagged together is a store: mem_wen_in alone selects we.
   assign access        = dmem_alu_in | mem_wen_in;
   assign misalign_drop = (state == IDLE) & access & is_misaligned(alu_res_in[1:0]);
   assign issue         = (state == IDLE) & access & ~misalign_drop;
   assign ack_hit       = (state == REQ) & dmem_ack;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] tmo_cnt;
   logic             tmo_flag;

   // Down-counter loaded at issue; terminal count reached in the last
   // permitted REQ cycle. An ack in that same cycle still wins.
   assign tmo_hit = (state == REQ) & ~dmem_ack & (tmo_cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt  <= '0;
         tmo_flag <= 1'b0;
      end else begin
         if (issue)
            tmo_cnt <= CNT_W'(TIMEOUT_CYCLES - 1);
         else if ((state == REQ) && (tmo_cnt != '0))
            tmo_cnt <= tmo_cnt - 1'b1;
         if (tmo_hit)
            tmo_flag <= 1'b1;
      end
   end

   assign timeout_err = tmo_flag;
`else
   assign tmo_hit     = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // Stall falls in the ack (or abort) cycle so upstream advances on that edge.
   assign stall = ~rst & (issue | ((state == REQ) & ~dmem_ack & ~tmo_hit));

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_addr    <= '0;
         dmem_wdata   <= '0;
         misalign_err <= 1'b0;
      end else begin
         misalign_err <= misalign_drop;
         case (state)
            IDLE: begin
               if (issue) begin
                  state      <= REQ;
                  dmem_req   <= 1'b1;
                  dmem_we    <= mem_wen_in;
                  dmem_addr  <= alu_res_in;
                  dmem_wdata <= st_data_in;
               end
            end
            REQ: begin
               if (dmem_ack || tmo_hit) begin
                  state    <= IDLE;
                  dmem_req <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               dmem_req <= 1'b0;
            end
         endcase
      end
   end

   logic [DATA_W-1:0] wb_next_data;
   logic              wb_next_wen;

   // The latched we distinguishes a completing load from a completing store.
   assign wb_next_data = (ack_hit & ~dmem_we) ? dmem_rdata : alu_res_in;
   assign wb_next_wen  = reg_wen_in & ~misalign_drop & ~tmo_hit;

   mem_wb_reg #(
      .DATA_W (DATA_W)
   ) u_mem_wb_reg (
      .clk          (clk),
      .rst          (rst),
      .bubble       (stall),
      .next_data    (wb_next_data),
      .next_reg_wen (wb_next_wen),
      .next_regd    (regd_in),
      .data         (wb_data),
      .reg_wen      (wb_reg_wen),
      .regd         (wb_regd)
   );

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
//   Scoreboard bench for mem_stage: stimulus pushes expected bus requests and
//   expected register writebacks into queues; a negedge monitor pops and
//   compares whenever the DUT starts a bus request or asserts wb_reg_wen.
//   With MEM_TIMEOUT_EN defined the watchdog path is exercised (depth 4).
module tb_mem_stage;

   localparam int DW  = 32;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] alu_res_in, st_data_in;
   logic          reg_wen_in, dmem_alu_in, mem_wen_in;
   logic [4:0]    regd_in;
   logic          dmem_req, dmem_we;
   logic [DW-1:0] dmem_addr, dmem_wdata;
   logic          dmem_ack;
   logic [DW-1:0] dmem_rdata;
   logic          stall, misalign_err, timeout_err;
   logic [DW-1:0] wb_data;
   logic          wb_reg_wen;
   logic [4:0]    wb_regd;

   always #5 clk = ~clk;

   mem_stage #(
      .DATA_W (DW)
`ifdef MEM_TIMEOUT_EN
      , .TIMEOUT_CYCLES (TMO)
`endif
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .alu_res_in   (alu_res_in),
      .st_data_in   (st_data_in),
      .reg_wen_in   (reg_wen_in),
      .dmem_alu_in  (dmem_alu_in),
      .mem_wen_in   (mem_wen_in),
      .regd_in      (regd_in),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_wdata   (dmem_wdata),
      .dmem_ack     (dmem_ack),
      .dmem_rdata   (dmem_rdata),
      .stall        (stall),
      .misalign_err (misalign_err),
      .timeout_err  (timeout_err),
      .wb_data      (wb_data),
      .wb_reg_wen   (wb_reg_wen),
      .wb_regd      (wb_regd)
   );

   typedef struct packed {
      logic [DW-1:0] data;
      logic [4:0]    regd;
   } wb_t;

   typedef struct packed {
      logic          we;
      logic [DW-1:0] addr;
      logic [DW-1:0] wdata;
   } bus_t;

   wb_t  wb_q[$];
   bus_t bus_q[$];

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   logic prev_req = 1'b0;
   wb_t  mon_wb;
   bus_t mon_bus;

   always @(negedge clk) begin
      if (wb_reg_wen === 1'b1) begin
         if (wb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wb_unexpected: got write data %h regd %0d expected no write", wb_data, wb_regd);
         end else begin
            mon_wb = wb_q.pop_front();
            check("wb_data", wb_data, mon_wb.data);
            check("wb_regd", 32'(wb_regd), 32'(mon_wb.regd));
         end
      end
      if (dmem_req === 1'b1 && prev_req !== 1'b1) begin
         if (bus_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL bus_unexpected: got request addr %h expected no request", dmem_addr);
         end else begin
            mon_bus = bus_q.pop_front();
            check("bus_we", 32'(dmem_we), 32'(mon_bus.we));
            check("bus_addr", dmem_addr, mon_bus.addr);
            check("bus_wdata", dmem_wdata, mon_bus.wdata);
         end
      end
      prev_req <= dmem_req;
   end

   // ---------------- stimulus ----------------
   task automatic set_idle();
      alu_res_in  = '0;
      st_data_in  = '0;
      reg_wen_in  = 1'b0;
      dmem_alu_in = 1'b0;
      mem_wen_in  = 1'b0;
      regd_in     = '0;
      dmem_ack    = 1'b0;
      dmem_rdata  = '0;
   endtask

   // Called and returns at a negedge. Holds the instruction while stall is
   // high; acks on the (ack_after+1)-th request cycle.
   task automatic run_instr(input logic [31:0] alu, input logic [31:0] sd,
                            input logic rw, input logic ld, input logic st,
                            input logic [4:0] rd, input int ack_after,
                            input logic [31:0] rdata, input int budget,
                            output int stalls, output int reqs,
                            output int cycles, output bit done);
      alu_res_in  = alu;
      st_data_in  = sd;
      reg_wen_in  = rw;
      dmem_alu_in = ld;
      mem_wen_in  = st;
      regd_in     = rd;
      stalls = 0;
      reqs   = 0;
      cycles = 0;
      done   = 1'b0;
      while (!done && cycles < budget) begin
         dmem_ack   = dmem_req && (reqs == ack_after);
         dmem_rdata = dmem_ack ? rdata : 32'hDEAD_BEEF;
         #1;
         if (stall) stalls++;
         else done = 1'b1;
         if (dmem_req) reqs++;
         cycles++;
         @(negedge clk);
      end
      set_idle();
   endtask

   int stalls, reqs, cycles;
   bit done;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      set_idle();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_req", 32'(dmem_req), 0);
      check("rst_we", 32'(dmem_we), 0);
      check("rst_addr", dmem_addr, 0);
      check("rst_wdata", dmem_wdata, 0);
      check("rst_stall", 32'(stall), 0);
      check("rst_misalign", 32'(misalign_err), 0);
      check("rst_timeout", 32'(timeout_err), 0);
      check("rst_wb_data", wb_data, 0);
      check("rst_wb_wen", 32'(wb_reg_wen), 0);
      check("rst_wb_regd", 32'(wb_regd), 0);
      rst = 1'b0;
      @(negedge clk);

      // 1: ALU op, writeback next edge, never stalls
      wb_q.push_back('{data: 32'h0000_1234, regd: 5'd5});
      run_instr(32'h1234, 32'h0, 1'b1, 1'b0, 1'b0, 5'd5, 0, 32'h0, 10, stalls, reqs, cycles, done);
      check("alu_stalls", 32'(stalls), 0);
      check("alu_cycles", 32'(cycles), 1);
      check("alu_wb_wen", 32'(wb_reg_wen), 1);
      // ALU op without register write: no writeback expected
      run_instr(32'h5555, 32'h0, 1'b0, 1'b0, 1'b0, 5'd6, 0, 32'h0, 10, stalls, reqs, cycles, done);
      check("nowen_wb_wen", 32'(wb_reg_wen), 0);
      check("nowen_wb_data", wb_data, 32'h5555);

      // 2: load 0x40, ack in 4th request cycle
      bus_q.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'h0});
      wb_q.push_back('{data: 32'hCAFE_F00D, regd: 5'd7});
      run_instr(32'h40, 32'h0, 1'b1, 1'b1, 1'b0, 5'd7, 3, 32'hCAFE_F00D, 20, stalls, reqs, cycles, done);
      check("load_done", 32'(done), 1);
      check("load_stalls", 32'(stalls), 4);
      check("load_reqs", 32'(reqs), 4);
      check("load_req_dropped", 32'(dmem_req), 0);

      // 3: store 0x80, ack immediate: 2-cycle latency, no reg write
      bus_q.push_back('{we: 1'b1, addr: 32'h80, wdata: 32'hA5A5_A5A5});
      run_instr(32'h80, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b1, 5'd3, 0, 32'h0, 20, stalls, reqs, cycles, done);
      check("store_stalls", 32'(stalls), 1);
      check("store_cycles", 32'(cycles), 2);
      check("store_reqs", 32'(reqs), 1);
      check("store_wb_wen", 32'(wb_reg_wen), 0);
      check("store_req_dropped", 32'(dmem_req), 0);

      // load+store together behaves as store; writeback takes ALU result
      bus_q.push_back('{we: 1'b1, addr: 32'h104, wdata: 32'h1111_2222});
      wb_q.push_back('{data: 32'h104, regd: 5'd9});
      run_instr(32'h104, 32'h1111_2222, 1'b1, 1'b1, 1'b1, 5'd9, 1, 32'h9999_9999, 20, stalls, reqs, cycles, done);
      check("both_stalls", 32'(stalls), 2);
      // back-to-back load with no idle cycle between
      bus_q.push_back('{we: 1'b0, addr: 32'h200, wdata: 32'h0});
      wb_q.push_back('{data: 32'h0BAD_F00D, regd: 5'd12});
      run_instr(32'h200, 32'h0, 1'b1, 1'b1, 1'b0, 5'd12, 2, 32'h0BAD_F00D, 20, stalls, reqs, cycles, done);
      check("b2b_stalls", 32'(stalls), 3);
      @(negedge clk);

      // 4: misaligned load 0x42: dropped, pulse, no stall
      run_instr(32'h42, 32'h0, 1'b1, 1'b1, 1'b0, 5'd4, 0, 32'h0, 10, stalls, reqs, cycles, done);
      check("mis_ld_stalls", 32'(stalls), 0);
      check("mis_ld_pulse", 32'(misalign_err), 1);
      check("mis_ld_wb_wen", 32'(wb_reg_wen), 0);
      check("mis_ld_req", 32'(dmem_req), 0);
      @(negedge clk);
      check("mis_ld_pulse_end", 32'(misalign_err), 0);
      // misaligned store 0x81, then straight into the reset test
      run_instr(32'h81, 32'h7777_7777, 1'b1, 1'b0, 1'b1, 5'd13, 0, 32'h0, 10, stalls, reqs, cycles, done);
      check("mis_st_pulse", 32'(misalign_err), 1);
      check("mis_st_wb_wen", 32'(wb_reg_wen), 0);
      check("mis_st_wb_data", wb_data, 32'h81);

      // 5: reset while in REQ
      bus_q.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0});
      alu_res_in  = 32'h300;
      reg_wen_in  = 1'b1;
      dmem_alu_in = 1'b1;
      regd_in     = 5'd6;
      @(negedge clk);
      check("rstreq_req", 32'(dmem_req), 1);
      check("rstreq_pulse_end", 32'(misalign_err), 0);
      check("rstreq_wb_hold", wb_data, 32'h81);
      @(negedge clk);
      set_idle();
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("rstreq_req_drop", 32'(dmem_req), 0);
      check("rstreq_stall", 32'(stall), 0);
      check("rstreq_wb_data", wb_data, 0);
      check("rstreq_wb_wen", 32'(wb_reg_wen), 0);
      check("rstreq_wb_regd", 32'(wb_regd), 0);
      rst = 1'b0;
      @(negedge clk);
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h1234_5678;
      #1;
      check("late_ack_stall", 32'(stall), 0);
      @(negedge clk);
      set_idle();
      check("late_ack_req", 32'(dmem_req), 0);
      check("late_ack_wb_wen", 32'(wb_reg_wen), 0);

`ifdef MEM_TIMEOUT_EN
      // 6: no ack: watchdog aborts after TMO request cycles
      bus_q.push_back('{we: 1'b0, addr: 32'h400, wdata: 32'h0});
      run_instr(32'h400, 32'h0, 1'b1, 1'b1, 1'b0, 5'd8, 1000, 32'h0, 50, stalls, reqs, cycles, done);
      check("tmo_done", 32'(done), 1);
      check("tmo_reqs", 32'(reqs), TMO);
      check("tmo_stalls", 32'(stalls), TMO);
      check("tmo_err", 32'(timeout_err), 1);
      check("tmo_req_drop", 32'(dmem_req), 0);
      check("tmo_wb_wen", 32'(wb_reg_wen), 0);
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h5A5A_5A5A;
      @(negedge clk);
      set_idle();
      check("tmo_late_ack_req", 32'(dmem_req), 0);
      wb_q.push_back('{data: 32'h77, regd: 5'd2});
      run_instr(32'h77, 32'h0, 1'b1, 1'b0, 1'b0, 5'd2, 0, 32'h0, 10, stalls, reqs, cycles, done);
      check("tmo_err_sticky", 32'(timeout_err), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("tmo_err_cleared", 32'(timeout_err), 0);
`else
      // without the watchdog a request waits indefinitely
      bus_q.push_back('{we: 1'b0, addr: 32'h400, wdata: 32'h0});
      run_instr(32'h400, 32'h0, 1'b1, 1'b1, 1'b0, 5'd8, 1000, 32'h0, 30, stalls, reqs, cycles, done);
      check("wait_not_done", 32'(done), 0);
      check("wait_reqs", 32'(reqs), 29);
      check("wait_req_held", 32'(dmem_req), 1);
      check("wait_timeout_err", 32'(timeout_err), 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("wait_rst_req", 32'(dmem_req), 0);
`endif

      repeat (2) @(negedge clk);
      check("wb_q_empty", 32'(wb_q.size()), 0);
      check("bus_q_empty", 32'(bus_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
